// File: rtl/isqrt_seq_pkg.sv
// Shared definitions for the sequential integer square root: FSM encoding, counter sizing, rounding switch.
// Rounding build is selected with `define ISQRT_ROUND_EN.
package isqrt_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

`ifdef ISQRT_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

endpackage

// File: rtl/isqrt_step.sv
// One restoring square-root digit: folds two radicand bits into the remainder and decides one root bit.
// Latency: combinational. Backpressure: none (pure function of its inputs).
module isqrt_step #(
  parameter int W = 16
) (
  input  logic [W+1:0] rem,
  input  logic [W-1:0] root,
  input  logic [1:0]   bits,
  output logic [W+1:0] rem_next,
  output logic [W-1:0] root_next
);

  logic [W+3:0] rem_sh;
  logic [W+3:0] trial;
  logic         ge;

  // Widened so the shift never drops bits; the partial remainder entering a step is always < 2^W.
  always_comb begin
    rem_sh    = {rem, bits};
    trial     = {2'b00, root, 2'b01};
    ge        = (rem_sh >= trial);
    rem_next  = (W+2)'(ge ? (rem_sh - trial) : rem_sh);
    root_next = W'({root, ge});
  end

endmodule

// File: rtl/isqrt_seq.sv
// Sequential floor square root of a 2W-bit radicand with remainder; optional round-to-nearest root (ISQRT_ROUND_EN).
// Latency: out_valid rises W+1 edges after accept (W iterations + one result-register cycle).
// Backpressure: result held in DONE until out_ready; no new radicand accepted outside IDLE.
module isqrt_seq
  import isqrt_seq_pkg::*;
#(
  parameter int SRC_DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2*SRC_DATA_WIDTH-1:0]   radicand,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SRC_DATA_WIDTH-1:0]     root,
  output logic [SRC_DATA_WIDTH:0]       rem
);

  localparam int W     = SRC_DATA_WIDTH;
  localparam int CNT_W = clog2(W + 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2*W-1:0]   rad_q;
  logic [W+1:0]     wrem_q;
  logic [W-1:0]     wroot_q;
  logic [W-1:0]     root_q;
  logic [W:0]       rem_q;

  logic [W+1:0]     step_rem;
  logic [W-1:0]     step_root;
  logic             last_cycle;
  logic [W:0]       fin_rem;
  logic [W-1:0]     fin_root;

  isqrt_step #(.W(W)) u_step (
    .rem       (wrem_q),
    .root      (wroot_q),
    .bits      (rad_q[2*W-1 -: 2]),
    .rem_next  (step_rem),
    .root_next (step_root)
  );

  // Counter runs 0..W-1 for the digit iterations; count W is the result-register cycle.
  assign last_cycle = (cnt_q == CNT_W'(W));
  assign fin_rem    = (W+1)'(wrem_q);

`ifdef ISQRT_ROUND_EN
  logic [W:0] rnd_sum;
  always_comb begin
    rnd_sum  = {1'b0, wroot_q} + (W+1)'(fin_rem > {1'b0, wroot_q});
    fin_root = rnd_sum[W] ? {W{1'b1}} : rnd_sum[W-1:0];
  end
`else
  assign fin_root = wroot_q;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = CALC;
      CALC:    if (last_cycle) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rad_q   <= '0;
      wrem_q  <= '0;
      wroot_q <= '0;
      root_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            rad_q   <= radicand;
            wrem_q  <= '0;
            wroot_q <= '0;
            cnt_q   <= '0;
          end
        end
        CALC: begin
          if (last_cycle) begin
            root_q <= fin_root;
            rem_q  <= fin_rem;
          end else begin
            wrem_q  <= step_rem;
            wroot_q <= step_root;
            rad_q   <= rad_q << 2;
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign root      = root_q;
  assign rem       = rem_q;

endmodule
